// File: rtl/plic_pkg.sv
// Shared types and helpers for the PLIC target slice.
// Width helpers, claim FSM encoding and the null interrupt ID.
package plic_pkg;

  function automatic int id_bits(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int prio_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD1 = 2'd1,
    ST_HOLD2 = 2'd2
  } claim_st_e;

  localparam int ID_NONE = 0;

endpackage

// File: rtl/plic_prio_tree.sv
// Combinational argmax over eligible sources, built as a recursive pair tree.
// Lower index wins ties; no eligible source yields ID 0 with priority 0.
module plic_prio_tree
  import plic_pkg::*;
#(
  parameter int N    = 16,
  parameter int PW   = 3,
  parameter int IW   = 5,
  parameter int BASE = 0
) (
  input  logic [N-1:0]    elig_i,
  input  logic [N*PW-1:0] prio_i,
  output logic [IW-1:0]   best_id_o,
  output logic [PW-1:0]   best_prio_o
);

  if (N == 1) begin : g_leaf
    assign best_id_o   = elig_i[0] ? IW'(BASE + 1) : IW'(ID_NONE);
    assign best_prio_o = elig_i[0] ? prio_i : '0;
  end else begin : g_node
    localparam int NL = N / 2;
    localparam int NH = N - NL;

    logic [IW-1:0] id_l, id_h;
    logic [PW-1:0] p_l, p_h;
    logic          hi_win;

    plic_prio_tree #(
      .N(NL), .PW(PW), .IW(IW), .BASE(BASE)
    ) u_lo (
      .elig_i     (elig_i[NL-1:0]),
      .prio_i     (prio_i[NL*PW-1:0]),
      .best_id_o  (id_l),
      .best_prio_o(p_l)
    );

    plic_prio_tree #(
      .N(NH), .PW(PW), .IW(IW), .BASE(BASE + NL)
    ) u_hi (
      .elig_i     (elig_i[N-1:NL]),
      .prio_i     (prio_i[N*PW-1:NL*PW]),
      .best_id_o  (id_h),
      .best_prio_o(p_h)
    );

    // strict compare keeps ties on the lower half
    assign hi_win      = p_h > p_l;
    assign best_id_o   = hi_win ? id_h : id_l;
    assign best_prio_o = hi_win ? p_h : p_l;
  end

endmodule

// File: rtl/plic_target.sv
// One PLIC interrupt target: source selection, ireq, claim FSM and
// one-cycle claim/complete strobes back to the gateways.
module plic_target
  import plic_pkg::*;
#(
  parameter  int SOURCES    = 16,
  parameter  int PRIORITIES = 8,
  localparam int SRC_BITS   = id_bits(SOURCES),
  localparam int PRIO_BITS  = prio_bits(PRIORITIES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SOURCES-1:0]           ip,
  input  logic [SOURCES-1:0]           ie,
  input  logic [SOURCES*PRIO_BITS-1:0] prio,
  input  logic [PRIO_BITS-1:0]         threshold,
  input  logic                         claim_rd,
  input  logic                         complete_wr,
  input  logic [SRC_BITS-1:0]          complete_id,
  output logic                         ireq,
  output logic [SRC_BITS-1:0]          id,
  output logic [SRC_BITS-1:0]          claim_id,
  output logic [SOURCES-1:0]           claim,
  output logic [SOURCES-1:0]           complete
);

  logic [SOURCES-1:0]   elig;
  logic [SRC_BITS-1:0]  best_id;
  logic [PRIO_BITS-1:0] best_prio;

  logic [SRC_BITS-1:0]  id_q;
  logic [PRIO_BITS-1:0] bprio_q;
  logic [PRIO_BITS-1:0] thr_q;
  claim_st_e            state_q;
  logic [SRC_BITS-1:0]  claim_id_q;
  logic [SOURCES-1:0]   claim_q;
  logic [SOURCES-1:0]   complete_q, complete_d;
  logic [SOURCES-1:0]   id_oh;
  logic                 ireq_int;

  always_comb begin
    elig       = '0;
    id_oh      = '0;
    complete_d = '0;
    for (int i = 0; i < SOURCES; i++) begin
      elig[i] = ip[i] & ie[i] &
                (prio[i*PRIO_BITS +: PRIO_BITS] != '0);
      id_oh[i] = (id_q == SRC_BITS'(i + 1));
      complete_d[i] = complete_wr & ie[i] &
                      (complete_id == SRC_BITS'(i + 1));
    end
  end

  plic_prio_tree #(
    .N(SOURCES), .PW(PRIO_BITS), .IW(SRC_BITS), .BASE(0)
  ) u_tree (
    .elig_i     (elig),
    .prio_i     (prio),
    .best_id_o  (best_id),
    .best_prio_o(best_prio)
  );

  // hold states mask ireq while the gateway drops ip and id catches up
  assign ireq_int = (state_q == ST_IDLE) && (bprio_q > thr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      bprio_q    <= '0;
      thr_q      <= '0;
      complete_q <= '0;
    end else begin
      id_q       <= best_id;
      bprio_q    <= best_prio;
      thr_q      <= threshold;
      complete_q <= complete_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      claim_id_q <= '0;
      claim_q    <= '0;
    end else begin
      claim_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (claim_rd) begin
            if (ireq_int) begin
              claim_id_q <= id_q;
              claim_q    <= id_oh;
              state_q    <= ST_HOLD1;
            end else begin
              claim_id_q <= SRC_BITS'(ID_NONE);
            end
          end
        end
        ST_HOLD1: begin
          if (claim_rd) claim_id_q <= SRC_BITS'(ID_NONE);
          state_q <= ST_HOLD2;
        end
        ST_HOLD2: begin
          if (claim_rd) claim_id_q <= SRC_BITS'(ID_NONE);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ireq     = ireq_int;
  assign id       = id_q;
  assign claim_id = claim_id_q;
  assign claim    = claim_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_plic_target.sv
// Self-checking bench for plic_target: vector table, claim/complete
// sequences, then random traffic against a behavioural model.
module tb_plic_target;

  localparam int NS = 16;
  localparam int PB = 3;
  localparam int IB = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NS-1:0]  ip, ie;
  logic [NS*PB-1:0] prio;
  logic [PB-1:0]  threshold;
  logic           claim_rd, complete_wr;
  logic [IB-1:0]  complete_id;
  logic           ireq;
  logic [IB-1:0]  id, claim_id;
  logic [NS-1:0]  claim, complete;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  plic_target #(.SOURCES(NS), .PRIORITIES(8)) dut (
    .clk(clk), .rst_n(rst_n), .ip(ip), .ie(ie), .prio(prio),
    .threshold(threshold), .claim_rd(claim_rd),
    .complete_wr(complete_wr), .complete_id(complete_id),
    .ireq(ireq), .id(id), .claim_id(claim_id),
    .claim(claim), .complete(complete)
  );

  typedef struct {
    logic [NS-1:0]    ip;
    logic [NS-1:0]    ie;
    logic [NS*PB-1:0] prio;
    logic [PB-1:0]    thr;
    logic [IB-1:0]    exp_id;
    logic             exp_ireq;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NS*PB-1:0] setp(
      input logic [NS*PB-1:0] p, input int src, input int v);
    logic [PB-1:0] pv;
    pv = PB'(v);
    p[src*PB +: PB] = pv;
    return p;
  endfunction

  // reference: scan IDs upward, keep strictly better priority
  function automatic void mbest(input logic [NS-1:0] vip,
      input logic [NS-1:0] vie, input logic [NS*PB-1:0] vp,
      output int bid, output int bp);
    bid = 0;
    bp  = 0;
    for (int i = 0; i < NS; i++) begin
      int p;
      p = int'(vp[i*PB +: PB]);
      if (vip[i] && vie[i] && p > bp) begin
        bp  = p;
        bid = i + 1;
      end
    end
  endfunction

  logic [NS*PB-1:0] p0;
  int m_id, m_bp, m_thr, m_hold, m_cid;
  logic [NS-1:0] m_claim, m_comp;

  initial begin
    rst_n = 1'b0;
    ip = '0; ie = '0; prio = '0; threshold = '0;
    claim_rd = 1'b0; complete_wr = 1'b0; complete_id = '0;
    #2;
    chk("rst_ireq", 32'(ireq), 0);
    chk("rst_id", 32'(id), 0);
    chk("rst_claim_id", 32'(claim_id), 0);
    chk("rst_claim", 32'(claim), 0);
    chk("rst_complete", 32'(complete), 0);
    step();
    rst_n = 1'b1;
    step();

    p0 = setp(setp('0, 2, 5), 6, 5);
    vt[0] = '{16'h0044, 16'hFFFF, p0, 3'd0, 5'd3, 1'b1};
    vt[1] = '{16'h0044, 16'hFFFF, p0, 3'd5, 5'd3, 1'b0};
    vt[2] = '{16'h0044, 16'hFFFF, p0, 3'd4, 5'd3, 1'b1};
    vt[3] = '{16'h0044, 16'hFFFB, p0, 3'd0, 5'd7, 1'b1};
    vt[4] = '{16'h0044, 16'hFFFF, setp(p0, 6, 6), 3'd0, 5'd7, 1'b1};
    vt[5] = '{16'h0044, 16'hFFFF, '0, 3'd0, 5'd0, 1'b0};
    vt[6] = '{16'hFFFF, 16'hFFFF, setp(p0, 15, 7), 3'd7, 5'd16, 1'b0};
    vt[7] = '{16'hFFFF, 16'hFFFF, setp(p0, 15, 7), 3'd6, 5'd16, 1'b1};
    vt[8] = '{16'h0000, 16'hFFFF, p0, 3'd0, 5'd0, 1'b0};

    for (int k = 0; k < 9; k++) begin
      ip = vt[k].ip; ie = vt[k].ie;
      prio = vt[k].prio; threshold = vt[k].thr;
      step();
      chk($sformatf("vec%0d_id", k), 32'(id), 32'(vt[k].exp_id));
      chk($sformatf("vec%0d_ireq", k), 32'(ireq),
          32'(vt[k].exp_ireq));
    end

    // claim then retries during the hold window
    ip = 16'h0044; ie = 16'hFFFF; prio = p0; threshold = '0;
    step();
    claim_rd = 1'b1;
    step();
    chk("clm_id", 32'(claim_id), 3);
    chk("clm_strobe", 32'(claim), 32'h0004);
    chk("clm_ireq_hold1", 32'(ireq), 0);
    ip = 16'h0040;
    step();
    chk("hold1_claim_id", 32'(claim_id), 0);
    chk("hold1_claim", 32'(claim), 0);
    chk("hold2_ireq", 32'(ireq), 0);
    step();
    chk("hold2_claim_id", 32'(claim_id), 0);
    chk("hold2_claim", 32'(claim), 0);
    chk("after_hold_id", 32'(id), 7);
    chk("after_hold_ireq", 32'(ireq), 1);

    // claim and complete in the same cycle
    claim_rd = 1'b1; complete_wr = 1'b1; complete_id = 5'd3;
    step();
    chk("both_claim", 32'(claim), 32'h0040);
    chk("both_complete", 32'(complete), 32'h0004);
    chk("both_claim_id", 32'(claim_id), 7);
    claim_rd = 1'b0; complete_wr = 1'b0;
    step();
    chk("both_claim_off", 32'(claim), 0);
    chk("both_complete_off", 32'(complete), 0);
    step();

    // complete filtering
    ie = 16'hFFEF;
    complete_wr = 1'b1;
    complete_id = 5'd0;  step(); chk("cmp_id0", 32'(complete), 0);
    complete_id = 5'd17; step(); chk("cmp_id17", 32'(complete), 0);
    complete_id = 5'd5;  step(); chk("cmp_dis", 32'(complete), 0);
    complete_id = 5'd16; step(); chk("cmp_16", 32'(complete), 32'h8000);
    complete_wr = 1'b0;
    step();
    chk("cmp_16_off", 32'(complete), 0);
    ie = 16'hFFFF;

    // zero priority: nothing to claim
    prio = '0;
    step();
    chk("p0_id", 32'(id), 0);
    chk("p0_ireq", 32'(ireq), 0);
    claim_rd = 1'b1;
    step();
    claim_rd = 1'b0;
    chk("p0_claim_id", 32'(claim_id), 0);
    chk("p0_claim", 32'(claim), 0);

    // reset while in HOLD1
    ip = 16'h0044; prio = p0;
    step();
    claim_rd = 1'b1;
    step();
    claim_rd = 1'b0;
    chk("pre_rst_claim", 32'(claim), 32'h0004);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_claim", 32'(claim), 0);
    chk("mid_rst_claim_id", 32'(claim_id), 0);
    chk("mid_rst_id", 32'(id), 0);
    chk("mid_rst_ireq", 32'(ireq), 0);
    chk("mid_rst_complete", 32'(complete), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_id", 32'(id), 3);
    chk("post_rst_ireq", 32'(ireq), 1);

    // random traffic against the model, from a clean reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_id = 0; m_bp = 0; m_thr = 0; m_hold = 0; m_cid = 0;
    m_claim = '0; m_comp = '0;
    for (int n = 0; n < 400; n++) begin
      logic m_ireq;
      int cid;
      ip = NS'($urandom);
      ie = NS'($urandom | $urandom);
      prio = {16'($urandom), 32'($urandom)};
      threshold = PB'($urandom_range(0, 7));
      claim_rd = ($urandom_range(0, 2) == 0);
      complete_wr = $urandom_range(0, 1) == 1;
      cid = $urandom_range(0, 20);
      complete_id = IB'(cid);

      m_ireq = (m_hold == 0) && (m_bp > m_thr);
      m_claim = '0;
      m_hold = (m_hold == 1) ? 2 : 0;
      if (claim_rd) begin
        if (m_ireq) begin
          m_cid = m_id;
          m_claim = NS'(1) << (m_id - 1);
          m_hold = 1;
        end else begin
          m_cid = 0;
        end
      end
      m_comp = '0;
      if (complete_wr && cid >= 1 && cid <= NS && ie[cid-1])
        m_comp = NS'(1) << (cid - 1);
      mbest(ip, ie, prio, m_id, m_bp);
      m_thr = int'(threshold);

      step();
      chk("rnd_id", 32'(id), 32'(m_id));
      chk("rnd_ireq", 32'(ireq),
          32'((m_hold == 0) && (m_bp > m_thr)));
      chk("rnd_claim_id", 32'(claim_id), 32'(m_cid));
      chk("rnd_claim", 32'(claim), 32'(m_claim));
      chk("rnd_complete", 32'(complete), 32'(m_comp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
